// File: rtl/data_mem_responder.sv
// Wait-stated data-memory responder: accepts one load/store in IDLE, acks after WAIT_CYCLES.
// Optional DMEM_ERR_CHECK_EN flags misaligned or out-of-range addresses and suppresses their effect.
module data_mem_responder #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state, next_state;
  logic [3:0]        wait_cnt;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_data;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_data;
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              accept;
  logic              commit;
  logic [31:0]       mem [DEPTH];

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          accept     = 1'b1;
          next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT:    if (wait_cnt == WAIT_LAST) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the access commits on the accepting edge, so use the live inputs there.
  always_comb begin
    cur_we   = req_we;
    cur_addr = req_addr;
    cur_data = req_data;
    if (state == IDLE) begin
      cur_we   = we_i;
      cur_addr = addr_i;
      cur_data = data_i;
    end
  end

  assign idx    = cur_addr[IDX_W+1:2];
  assign commit = (next_state == RESP);

`ifdef DMEM_ERR_CHECK_EN
  assign addr_err = (|cur_addr[1:0]) || (|cur_addr[31:IDX_W+2]);
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{cur_addr[31:IDX_W+2], cur_addr[1:0]};
`endif

  // NOTE: state and registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        wait_cnt <= 4'd0;
        req_we   <= we_i;
        req_addr <= addr_i;
        req_data <= data_i;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= commit;
      err_o <= commit && addr_err;
      if (commit && !cur_we && !addr_err) data_o <= mem[idx];
    end
  end

  // NOTE: the array is cleared by reset, so it must stay in flops rather than a RAM macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && cur_we && !addr_err) begin
      mem[idx] <= cur_data;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: randomized load/store traffic against an array model.
// Expected error behaviour follows whether DMEM_ERR_CHECK_EN is defined for the build.
module tb_data_mem_responder;

  localparam int DEPTH = 128;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_dout;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (req),
    .we_i  (we),
    .addr_i(addr),
    .data_i(wdata),
    .ack_o (ack),
    .data_o(rdata),
    .err_o (err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_dout = '0;
  endfunction

  function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_ERR_CHECK_EN
    return (a % 4 != 0) || (a / (4 * DEPTH) != 0);
`else
    return (a == a) ? 1'b0 : 1'b1;
`endif
  endfunction

  // Applies one access to the model; returns the expected error flag.
  function automatic logic model_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic e;
    int   word;
    e    = model_err(a);
    word = int'((a / 4) % DEPTH);
    if (!e) begin
      if (w) model_mem[word] = d;
      else   model_dout      = model_mem[word];
    end
    return e;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One complete request: drive, observe the whole handshake, compare with the model.
  task automatic transact(input string name, input logic w, input logic [31:0] a, input logic [31:0] d);
    int          ack_cnt = 0;
    int          ack_at = -1;
    int          busy_cnt = 0;
    logic [31:0] got_d = '0;
    logic        got_e = 1'b0;
    logic        exp_e;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 1; k <= WC + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0; we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
      end
      if (busy) busy_cnt++;
      if (ack) begin
        ack_cnt++;
        ack_at = k;
        got_d  = rdata;
        got_e  = err;
      end
    end
    exp_e = model_access(w, a, d);
    check_int({name, " ack_count"}, ack_cnt, 1);
    check_int({name, " ack_cycle"}, ack_at, WC + 1);
    check_int({name, " busy_cycles"}, busy_cnt, WC + 1);
    check_word({name, " data"}, got_d, model_dout);
    check_bit({name, " err"}, got_e, exp_e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_bit("reset ack", ack, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset err", err, 1'b0);
    check_word("reset data", rdata, 32'h0);
    rst = 1'b0;
    transact("reset_read0", 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_write_read();
    transact("wr_10", 1'b1, 32'h10, 32'hDEADBEEF);
    transact("rd_10", 1'b0, 32'h10, 32'h0);
    check_word("rd_10 deadbeef", model_dout, 32'hDEADBEEF);
  endtask

  task automatic test_ignored();
    int ack_cnt = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1;
    if (ack) ack_cnt++;
    @(negedge clk);
    if (ack) ack_cnt++;
    @(negedge clk);
    req = 1'b0;
    if (ack) ack_cnt++;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
    end
    void'(model_access(1'b0, 32'h0, 32'h0));
    check_int("ignored ack_count", ack_cnt, 1);
    transact("ignored_rd_20", 1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_back_to_back();
    int          ack_times[$];
    logic [31:0] ack_data[$];
    logic [31:0] exp_d;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (ack) begin ack_times.push_back(c); ack_data.push_back(rdata); end
    end
    req = 1'b0;
    for (int c = 31; c <= 40; c++) begin
      @(negedge clk);
      if (ack) begin ack_times.push_back(c); ack_data.push_back(rdata); end
    end
    void'(model_access(1'b0, 32'h10, 32'h0));
    exp_d = model_dout;
    check_int("b2b ack_count", ack_times.size(), 8);
    if (ack_times.size() > 0) check_int("b2b first_ack", ack_times[0], WC + 1);
    for (int i = 1; i < ack_times.size(); i++)
      check_int("b2b spacing", ack_times[i] - ack_times[i-1], WC + 2);
    foreach (ack_data[i]) check_word("b2b data", ack_data[i], exp_d);
  endtask

  task automatic test_error();
    transact("err_wr_13", 1'b1, 32'h13, 32'hCAFEF00D);
    transact("err_rd_10", 1'b0, 32'h10, 32'h0);
    transact("err_wr_200", 1'b1, 32'h200, 32'h12345678);
    transact("err_rd_0", 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, 15)) * 4;
        2:       a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      transact("random", 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  task automatic test_reset_mid();
    int ack_cnt = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_bit("midrst ack", ack, 1'b0);
    check_bit("midrst busy", busy, 1'b0);
    check_bit("midrst err", err, 1'b0);
    check_word("midrst data", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack) ack_cnt++;
    end
    check_int("midrst ack_count", ack_cnt, 0);
    transact("midrst_rd_8", 1'b0, 32'h8, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ignored();
    test_back_to_back();
    test_error();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
